dsp_file_arbiter: RTL and testbench

Round-robin arbiter that shares the single DSP file-controller port among up to `NUM_REQ` DSP equation engines (dtree, FIR, etc.). Each engine keeps its existing file handshake unchanged: hold a read/write/reset command until `file_active` rises, drop it, then wait for `file_active` to fall. The arbiter sits between the engines and the file controller. It grants one complete transaction at a time, forwards the winner's command fields, and routes `file_active` back to the winner only.

---
 rtl/dsp_file_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_dsp_file_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_file_arbiter.sv
// Round-robin arbiter sharing one DSP file-controller port among NUM_REQ engines.
// Define DSP_FILE_ARB_TIMEOUT_EN to add the GRANT-phase timeout and timeout_err flags.
module dsp_file_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                   wb_clk,
   input  logic                   wb_rst_n,
   input  logic [NUM_REQ*8-1:0]   req_file_num,
   input  logic [NUM_REQ-1:0]     req_file_read,
   input  logic [NUM_REQ-1:0]     req_file_write,
   input  logic [NUM_REQ-1:0]     req_file_reset,
   input  logic [NUM_REQ*32-1:0]  req_rd_ptr_offset,
   input  logic [NUM_REQ*32-1:0]  req_write_data,
   output logic [NUM_REQ-1:0]     req_file_active,
   output logic [31:0]            req_read_data,
   output logic [7:0]             file_num,
   output logic                   file_read,
   output logic                   file_write,
   output logic                   file_reset,
   output logic [31:0]            file_rd_ptr_offset,
   output logic [31:0]            file_write_data,
   input  logic [31:0]            file_read_data,
   input  logic                   file_active,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic [NUM_REQ-1:0]     cmd_err,
   output logic [NUM_REQ-1:0]     timeout_err,
   input  logic                   err_clear
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
      $error("dsp_file_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_t;

   state_t               state_q;
   logic [IW-1:0]        last_q;
   logic [IW-1:0]        owner_q;
   logic [NUM_REQ-1:0]   grant_q;
   logic [7:0]           file_num_q;
   logic                 file_read_q;
   logic                 file_write_q;
   logic                 file_reset_q;
   logic [31:0]          offset_q;
   logic [31:0]          wdata_q;
   logic [NUM_REQ-1:0]   cmd_err_q;
   logic [NUM_REQ-1:0]   cmd_err_d;

   logic [NUM_REQ-1:0]   req;
   logic                 win_found;
   logic [IW-1:0]        win_idx;
   int unsigned          cand;
   logic [IW-1:0]        sel_idx;
   logic [NUM_REQ-1:0]   sel_oh;
   logic                 s_rd, s_wr, s_rs;
   logic                 fwd_rd, fwd_wr, fwd_rs;
   logic                 multi_cmd;
   logic                 launch;
   logic [NUM_REQ-1:0]   cmd_set;
   logic                 tmo_hit;

   assign req = req_file_read | req_file_write | req_file_reset;

   // Rotating priority: scan from last+1, first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = (32'(last_q) + k) % NUM_REQ;
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = IW'(cand);
         end
      end
   end

   always_comb begin
      sel_idx   = (state_q == S_GRANT) ? owner_q : win_idx;
      sel_oh    = NUM_REQ'(1) << sel_idx;
      s_rd      = req_file_read[sel_idx];
      s_wr      = req_file_write[sel_idx];
      s_rs      = req_file_reset[sel_idx];
      fwd_rs    = s_rs;
      fwd_wr    = s_wr & ~s_rs;
      fwd_rd    = s_rd & ~s_wr & ~s_rs;
      multi_cmd = (s_rd & s_wr) | (s_rd & s_rs) | (s_wr & s_rs);
      launch    = (state_q == S_IDLE) && win_found && !file_active;
      cmd_set   = ((launch || state_q == S_GRANT) && multi_cmd) ? sel_oh : '0;
      cmd_err_d = (cmd_err_q & ~{NUM_REQ{err_clear}}) | cmd_set;
   end

`ifdef DSP_FILE_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0]        tmo_q;
   logic [NUM_REQ-1:0]   timeout_err_q;
   logic [NUM_REQ-1:0]   timeout_err_d;

   assign tmo_hit       = (state_q == S_GRANT) && !file_active && (tmo_q == TW'(TIMEOUT - 1));
   assign timeout_err_d = (timeout_err_q & ~{NUM_REQ{err_clear}}) | (tmo_hit ? sel_oh : '0);

   // Counter is held at zero outside GRANT, so it restarts on every entry.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         tmo_q         <= '0;
         timeout_err_q <= '0;
      end else begin
         timeout_err_q <= timeout_err_d;
         if (state_q == S_GRANT) tmo_q <= tmo_q + TW'(1);
         else                    tmo_q <= '0;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = '0;
`endif

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q      <= S_IDLE;
         last_q       <= IW'(NUM_REQ - 1);
         owner_q      <= '0;
         grant_q      <= '0;
         file_num_q   <= '0;
         file_read_q  <= 1'b0;
         file_write_q <= 1'b0;
         file_reset_q <= 1'b0;
         offset_q     <= '0;
         wdata_q      <= '0;
         cmd_err_q    <= '0;
      end else begin
         cmd_err_q <= cmd_err_d;
         case (state_q)
            S_IDLE: begin
               grant_q      <= '0;
               file_read_q  <= 1'b0;
               file_write_q <= 1'b0;
               file_reset_q <= 1'b0;
               if (launch) begin
                  state_q      <= S_GRANT;
                  owner_q      <= win_idx;
                  last_q       <= win_idx;
                  grant_q      <= sel_oh;
                  file_num_q   <= req_file_num[8*sel_idx +: 8];
                  offset_q     <= req_rd_ptr_offset[32*sel_idx +: 32];
                  wdata_q      <= req_write_data[32*sel_idx +: 32];
                  file_read_q  <= fwd_rd;
                  file_write_q <= fwd_wr;
                  file_reset_q <= fwd_rs;
               end
            end
            S_GRANT: begin
               if (file_active || tmo_hit) begin
                  state_q      <= file_active ? S_BUSY : S_RELEASE;
                  file_read_q  <= 1'b0;
                  file_write_q <= 1'b0;
                  file_reset_q <= 1'b0;
               end else begin
                  file_num_q   <= req_file_num[8*sel_idx +: 8];
                  offset_q     <= req_rd_ptr_offset[32*sel_idx +: 32];
                  wdata_q      <= req_write_data[32*sel_idx +: 32];
                  file_read_q  <= fwd_rd;
                  file_write_q <= fwd_wr;
                  file_reset_q <= fwd_rs;
               end
            end
            S_BUSY: begin
               if (!file_active) state_q <= S_RELEASE;
            end
            S_RELEASE: begin
               state_q <= S_IDLE;
               grant_q <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_file_active    = {NUM_REQ{file_active}} & grant_q;
   assign req_read_data      = file_read_data;
   assign file_num           = file_num_q;
   assign file_read          = file_read_q;
   assign file_write         = file_write_q;
   assign file_reset         = file_reset_q;
   assign file_rd_ptr_offset = offset_q;
   assign file_write_data    = wdata_q;
   assign grant              = grant_q;
   assign busy               = (state_q != S_IDLE);
   assign cmd_err            = cmd_err_q;

endmodule

// File: tb/tb_dsp_file_arbiter.sv
// Directed self-checking bench for dsp_file_arbiter (NUM_REQ=4, TIMEOUT=16).
module tb_dsp_file_arbiter;

   localparam int unsigned N = 4;

   logic            wb_clk = 1'b0;
   logic            wb_rst_n = 1'b0;
   logic [N*8-1:0]  req_file_num = '0;
   logic [N-1:0]    req_file_read = '0;
   logic [N-1:0]    req_file_write = '0;
   logic [N-1:0]    req_file_reset = '0;
   logic [N*32-1:0] req_rd_ptr_offset = '0;
   logic [N*32-1:0] req_write_data = '0;
   logic [N-1:0]    req_file_active;
   logic [31:0]     req_read_data;
   logic [7:0]      file_num;
   logic            file_read, file_write, file_reset;
   logic [31:0]     file_rd_ptr_offset, file_write_data;
   logic [31:0]     file_read_data = 32'h0;
   logic            file_active = 1'b0;
   logic [N-1:0]    grant;
   logic            busy;
   logic [N-1:0]    cmd_err;
   logic [N-1:0]    timeout_err;
   logic            err_clear = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   dsp_file_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
      .req_file_num(req_file_num), .req_file_read(req_file_read),
      .req_file_write(req_file_write), .req_file_reset(req_file_reset),
      .req_rd_ptr_offset(req_rd_ptr_offset), .req_write_data(req_write_data),
      .req_file_active(req_file_active), .req_read_data(req_read_data),
      .file_num(file_num), .file_read(file_read), .file_write(file_write),
      .file_reset(file_reset), .file_rd_ptr_offset(file_rd_ptr_offset),
      .file_write_data(file_write_data), .file_read_data(file_read_data),
      .file_active(file_active), .grant(grant), .busy(busy),
      .cmd_err(cmd_err), .timeout_err(timeout_err), .err_clear(err_clear)
   );

   always #5 wb_clk = ~wb_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic do_reset();
      wb_rst_n       = 1'b0;
      req_file_read  = '0;
      req_file_write = '0;
      req_file_reset = '0;
      file_active    = 1'b0;
      err_clear      = 1'b0;
      step();
      step();
      wb_rst_n = 1'b1;
      step();
   endtask

   // Arbiter idle with requests pending: grant next edge, one-cycle file_active pulse.
   task automatic serve(input string tag, input int idx, input logic [7:0] exp_num);
      step();
      check({tag, "_grant"}, 32'(grant), 32'(1) << idx);
      check({tag, "_num"}, 32'(file_num), 32'(exp_num));
      check({tag, "_strobes"}, 32'({file_reset, file_write, file_read}),
            32'({req_file_reset[idx], req_file_write[idx] & ~req_file_reset[idx],
                 req_file_read[idx] & ~req_file_write[idx] & ~req_file_reset[idx]}));
      file_active = 1'b1;
      #1;
      check({tag, "_ractive"}, 32'(req_file_active), 32'(1) << idx);
      step();
      check({tag, "_busy_strobes"}, 32'({busy, file_read, file_write, file_reset}), 32'b1000);
      req_file_read[idx]  = 1'b0;
      req_file_write[idx] = 1'b0;
      req_file_reset[idx] = 1'b0;
      file_active = 1'b0;
      step();
      check({tag, "_release"}, 32'({busy, grant}), {27'd0, 1'b1, 4'(32'(1) << idx)});
      step();
      check({tag, "_idle"}, 32'({busy, grant}), 32'd0);
   endtask

   initial begin
      #2;
      check("reset_outputs", 32'({grant, busy, file_read, file_write, file_reset, cmd_err, timeout_err}), 32'd0);
      check("reset_num", 32'(file_num), 32'd0);
      do_reset();

      // Single read from requester 2, file 5, offset 0x10.
      req_file_num[8*2 +: 8]       = 8'd5;
      req_rd_ptr_offset[32*2 +: 32] = 32'h10;
      file_read_data               = 32'hCAFE0001;
      req_file_read[2]             = 1'b1;
      step();
      check("rd_grant", 32'(grant), 32'b0100);
      check("rd_strobe", 32'({file_read, file_write, file_reset}), 32'b100);
      check("rd_num", 32'(file_num), 32'd5);
      check("rd_offset", file_rd_ptr_offset, 32'h10);
      check("rd_busy", 32'(busy), 32'd1);
      step();
      step();
      file_active = 1'b1;
      #1;
      check("rd_ractive", 32'(req_file_active), 32'b0100);
      check("rd_rdata", req_read_data, 32'hCAFE0001);
      step();
      check("rd_busy_strobe", 32'({busy, file_read}), 32'b10);
      check("rd_hold_num", 32'(file_num), 32'd5);
      req_file_read[2] = 1'b0;
      step();
      file_active = 1'b0;
      #1;
      check("rd_ractive_low", 32'(req_file_active), 32'd0);
      step();
      check("rd_release", 32'({busy, grant}), 32'b10100);
      step();
      check("rd_idle", 32'({busy, grant}), 32'd0);

      // All four read at once after reset: served 0,1,2,3.
      do_reset();
      for (int i = 0; i < 4; i++) req_file_num[8*i +: 8] = 8'(i + 1);
      req_file_read = 4'b1111;
      serve("rr0", 0, 8'd1);
      serve("rr1", 1, 8'd2);
      serve("rr2", 2, 8'd3);
      serve("rr3", 3, 8'd4);

      // Requester 1 write+read: write forwarded, cmd_err sticky until cleared.
      req_write_data[32*1 +: 32] = 32'hDEADBEEF;
      req_file_num[8*1 +: 8]     = 8'd9;
      req_file_write[1]          = 1'b1;
      req_file_read[1]           = 1'b1;
      step();
      check("wr_strobe", 32'({file_read, file_write, file_reset}), 32'b010);
      check("wr_data", file_write_data, 32'hDEADBEEF);
      check("wr_cmd_err", 32'(cmd_err), 32'b0010);
      file_active = 1'b1;
      step();
      req_file_write[1] = 1'b0;
      req_file_read[1]  = 1'b0;
      file_active = 1'b0;
      step();
      step();
      check("wr_cmd_err_sticky", 32'(cmd_err), 32'b0010);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("wr_cmd_err_clear", 32'(cmd_err), 32'd0);
      check("wr_no_timeout_err", 32'(timeout_err), 32'd0);

      // Reset while in BUSY.
      do_reset();
      req_file_read[0] = 1'b1;
      serve("pre", 0, 8'd1);
      req_file_read[2] = 1'b1;
      step();
      check("rst_pre_grant", 32'(grant), 32'b0100);
      file_active = 1'b1;
      step();
      check("rst_in_busy", 32'(busy), 32'd1);
      wb_rst_n = 1'b0;
      #1;
      check("rst_async_outs", 32'({grant, busy, file_read, file_write, file_reset, cmd_err}), 32'd0);
      check("rst_async_num", 32'(file_num), 32'd0);
      req_file_read = '0;
      file_active   = 1'b0;
      step();
      wb_rst_n = 1'b1;
      step();
      req_file_read = 4'b1001;
      serve("post_rst", 0, 8'd1);
      serve("post_rst_b", 3, 8'd4);

      // file_active high in IDLE blocks granting.
      file_active      = 1'b1;
      req_file_read[0] = 1'b1;
      step();
      step();
      step();
      check("blk_no_grant", 32'({busy, grant}), 32'd0);
      file_active = 1'b0;
      serve("blk", 0, 8'd1);

`ifdef DSP_FILE_ARB_TIMEOUT_EN
      // Controller never answers: release after 16 GRANT cycles.
      do_reset();
      req_file_read = 4'b0011;
      step();
      check("to_grant", 32'(grant), 32'b0001);
      for (int c = 1; c < 16; c++) step();
      check("to_last_grant_cycle", 32'({grant, file_read}), 32'b00011);
      step();
      check("to_release", 32'({busy, file_read}), 32'b10);
      check("to_err", 32'(timeout_err), 32'b0001);
      req_file_read[0] = 1'b0;
      step();
      check("to_idle", 32'(busy), 32'd0);
      serve("to_next", 1, 8'd2);
      check("to_err_sticky", 32'(timeout_err), 32'b0001);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
